// File: rtl/tlk2711_axil_reg_bridge_if.sv
// AXI4-Lite channel bundle between the PS HPM master and the TLK2711 register bridge.
// The master modport is the PS side and the slave modport is the bridge side.
interface tlk2711_axil_reg_bridge_if #(
  parameter int AXI_ADDR_WIDTH = 32
);
  logic [AXI_ADDR_WIDTH-1:0] s_axil_awaddr;
  logic                      s_axil_awvalid;
  logic                      s_axil_awready;
  logic [63:0]               s_axil_wdata;
  logic [7:0]                s_axil_wstrb;
  logic                      s_axil_wvalid;
  logic                      s_axil_wready;
  logic [1:0]                s_axil_bresp;
  logic                      s_axil_bvalid;
  logic                      s_axil_bready;
  logic [AXI_ADDR_WIDTH-1:0] s_axil_araddr;
  logic                      s_axil_arvalid;
  logic                      s_axil_arready;
  logic [63:0]               s_axil_rdata;
  logic [1:0]                s_axil_rresp;
  logic                      s_axil_rvalid;
  logic                      s_axil_rready;

  modport master (
    output s_axil_awaddr, s_axil_awvalid, s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
           s_axil_bready, s_axil_araddr, s_axil_arvalid, s_axil_rready,
    input  s_axil_awready, s_axil_wready, s_axil_bresp, s_axil_bvalid,
           s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid
  );

  modport slave (
    input  s_axil_awaddr, s_axil_awvalid, s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
           s_axil_bready, s_axil_araddr, s_axil_arvalid, s_axil_rready,
    output s_axil_awready, s_axil_wready, s_axil_bresp, s_axil_bvalid,
           s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid
  );
endinterface

// File: rtl/tlk2711_axil_reg_bridge.sv
// AXI4-Lite slave that turns each write or read into one TLK2711 register-bus transaction.
// One transaction outstanding at a time; write/read arbitration alternates when both are pending.
module tlk2711_axil_reg_bridge #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int REG_ADDR_LSB   = 3,
  parameter int RD_LATENCY     = 2
) (
  input  logic                    ps_clk,
  input  logic                    ps_rst,
  tlk2711_axil_reg_bridge_if.slave s_axil,
  output logic                    o_reg_wen,
  output logic [15:0]             o_reg_waddr,
  output logic [63:0]             o_reg_wdata,
  output logic                    o_reg_ren,
  output logic [15:0]             o_reg_raddr,
  input  logic [63:0]             i_reg_rdata
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] WR_COLLECT = 3'd1;
  localparam logic [2:0] WR_EXEC    = 3'd2;
  localparam logic [2:0] WR_RESP    = 3'd3;
  localparam logic [2:0] RD_EXEC    = 3'd4;
  localparam logic [2:0] RD_WAIT    = 3'd5;
  localparam logic [2:0] RD_RESP    = 3'd6;

  logic [2:0]  state_q, state_d;
  logic        aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [15:0] awaddr_q, awaddr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wstrb_q, wstrb_d;
  logic        last_wr_q, last_wr_d;
  logic [2:0]  lat_q, lat_d;
  logic        bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
  logic [63:0] rdata_q, rdata_d;
  logic        wen_q, wen_d, ren_q, ren_d;
  logic [15:0] waddr_q, waddr_d, raddr_q, raddr_d;
  logic [63:0] reg_wdata_q, reg_wdata_d;

  logic        awready, wready, arready, wr_start;
  logic        aw_hs, w_hs, ar_hs, got_aw, got_w;
  logic [15:0] eff_awaddr;
  logic [63:0] eff_wdata;
  logic [7:0]  eff_wstrb;
  logic [2*AXI_ADDR_WIDTH-1:0] unused_addr;

  assign unused_addr = {s_axil.s_axil_awaddr, s_axil.s_axil_araddr};

  // Write wins in IDLE unless a read is also pending and the previous transaction was a write.
  always_comb begin
    awready  = 1'b0;
    wready   = 1'b0;
    arready  = 1'b0;
    wr_start = (s_axil.s_axil_awvalid | s_axil.s_axil_wvalid) &
               (~s_axil.s_axil_arvalid | ~last_wr_q);
    if (!ps_rst) begin
      case (state_q)
        IDLE: begin
          if (wr_start) begin
            awready = s_axil.s_axil_awvalid;
            wready  = s_axil.s_axil_wvalid;
          end else begin
            arready = s_axil.s_axil_arvalid;
          end
        end
        WR_COLLECT: begin
          awready = s_axil.s_axil_awvalid & ~aw_held_q;
          wready  = s_axil.s_axil_wvalid & ~w_held_q;
        end
        default: ;
      endcase
    end
  end

  assign aw_hs = s_axil.s_axil_awvalid & awready;
  assign w_hs  = s_axil.s_axil_wvalid & wready;
  assign ar_hs = s_axil.s_axil_arvalid & arready;

  assign got_aw     = aw_held_q | aw_hs;
  assign got_w      = w_held_q | w_hs;
  assign eff_awaddr = aw_hs ? s_axil.s_axil_awaddr[REG_ADDR_LSB +: 16] : awaddr_q;
  assign eff_wdata  = w_hs ? s_axil.s_axil_wdata : wdata_q;
  assign eff_wstrb  = w_hs ? s_axil.s_axil_wstrb : wstrb_q;

  // The write strobe is registered on entry to WR_EXEC so it and its address/data
  // are glitch-free flop outputs during exactly the WR_EXEC cycle.
  always_comb begin
    state_d     = state_q;
    aw_held_d   = aw_held_q;
    w_held_d    = w_held_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    last_wr_d   = last_wr_q;
    lat_d       = lat_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    rvalid_d    = rvalid_q;
    rresp_d     = rresp_q;
    rdata_d     = rdata_q;
    wen_d       = 1'b0;
    ren_d       = 1'b0;
    waddr_d     = waddr_q;
    reg_wdata_d = reg_wdata_q;
    raddr_d     = raddr_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = s_axil.s_axil_awaddr[REG_ADDR_LSB +: 16];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_axil.s_axil_wdata;
      wstrb_d  = s_axil.s_axil_wstrb;
    end

    case (state_q)
      IDLE, WR_COLLECT: begin
        if ((aw_hs | w_hs) && got_aw && got_w) begin
          state_d = WR_EXEC;
          if (eff_wstrb == 8'hFF) begin
            wen_d       = 1'b1;
            waddr_d     = eff_awaddr;
            reg_wdata_d = eff_wdata;
          end
        end else if (aw_hs | w_hs) begin
          state_d = WR_COLLECT;
        end else if (ar_hs) begin
          state_d = RD_EXEC;
          ren_d   = 1'b1;
          raddr_d = s_axil.s_axil_araddr[REG_ADDR_LSB +: 16];
        end
      end
      WR_EXEC: begin
        bresp_d   = (wstrb_q == 8'hFF) ? 2'b00 : 2'b10;
        bvalid_d  = 1'b1;
        last_wr_d = 1'b1;
        aw_held_d = 1'b0;
        w_held_d  = 1'b0;
        state_d   = WR_RESP;
      end
      WR_RESP: begin
        if (s_axil.s_axil_bready) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      RD_EXEC: begin
        lat_d   = 3'(RD_LATENCY);
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (lat_q == 3'd1) begin
          rdata_d   = i_reg_rdata;
          rresp_d   = 2'b00;
          rvalid_d  = 1'b1;
          last_wr_d = 1'b0;
          state_d   = RD_RESP;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      RD_RESP: begin
        if (s_axil.s_axil_rready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ps_clk or posedge ps_rst) begin
    if (ps_rst) begin
      state_q     <= IDLE;
      aw_held_q   <= 1'b0;
      w_held_q    <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      last_wr_q   <= 1'b0;
      lat_q       <= '0;
      bvalid_q    <= 1'b0;
      bresp_q     <= '0;
      rvalid_q    <= 1'b0;
      rresp_q     <= '0;
      rdata_q     <= '0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      waddr_q     <= '0;
      reg_wdata_q <= '0;
      raddr_q     <= '0;
    end else begin
      state_q     <= state_d;
      aw_held_q   <= aw_held_d;
      w_held_q    <= w_held_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      last_wr_q   <= last_wr_d;
      lat_q       <= lat_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      rvalid_q    <= rvalid_d;
      rresp_q     <= rresp_d;
      rdata_q     <= rdata_d;
      wen_q       <= wen_d;
      ren_q       <= ren_d;
      waddr_q     <= waddr_d;
      reg_wdata_q <= reg_wdata_d;
      raddr_q     <= raddr_d;
    end
  end

  assign s_axil.s_axil_awready = awready;
  assign s_axil.s_axil_wready  = wready;
  assign s_axil.s_axil_arready = arready;
  assign s_axil.s_axil_bvalid  = bvalid_q;
  assign s_axil.s_axil_bresp   = bresp_q;
  assign s_axil.s_axil_rvalid  = rvalid_q;
  assign s_axil.s_axil_rresp   = rresp_q;
  assign s_axil.s_axil_rdata   = rdata_q;

  assign o_reg_wen   = wen_q;
  assign o_reg_waddr = waddr_q;
  assign o_reg_wdata = reg_wdata_q;
  assign o_reg_ren   = ren_q;
  assign o_reg_raddr = raddr_q;

endmodule

// File: tb/tb_tlk2711_axil_reg_bridge.sv
// Bench for tlk2711_axil_reg_bridge: transaction-level model scored every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_tlk2711_axil_reg_bridge;
  localparam int L = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tlk2711_axil_reg_bridge_if #(.AXI_ADDR_WIDTH(32)) axil ();

  logic        wen, ren;
  logic [15:0] waddr, raddr;
  logic [63:0] wdata_o, rdata_i;

  tlk2711_axil_reg_bridge #(
    .AXI_ADDR_WIDTH(32),
    .REG_ADDR_LSB  (3),
    .RD_LATENCY    (L)
  ) dut (
    .ps_clk      (clk),
    .ps_rst      (rst),
    .s_axil      (axil.slave),
    .o_reg_wen   (wen),
    .o_reg_waddr (waddr),
    .o_reg_wdata (wdata_o),
    .o_reg_ren   (ren),
    .o_reg_raddr (raddr),
    .i_reg_rdata (rdata_i)
  );

  int cmp_cnt = 0;
  int mis_cnt = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] reg_val(input logic [15:0] a);
    return {32'hDEAD_BEEF, 16'h0000, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      mis_cnt++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    cmp_cnt++;
    mis_cnt++;
    $display("FAIL timeout %s at cycle %0d: got no handshake, expected one", name, cyc);
  endtask

  // Register-side responder: returns reg_val(addr) exactly L cycles after the ren cycle, junk otherwise.
  int          rd_due = -1;
  logic [15:0] rd_addr = '0;
  always @(negedge clk) begin
    if (rst) rd_due = -1;
    else if (ren) begin
      rd_due  = cyc + L;
      rd_addr = raddr;
    end
    rdata_i = (rd_due == cyc) ? reg_val(rd_addr) : {$urandom, $urandom};
  end

  // Ready generators for the response channels.
  bit rnd_rdy = 1'b0;
  bit hold_r  = 1'b0;
  initial begin
    axil.s_axil_bready = 1'b0;
    axil.s_axil_rready = 1'b0;
    forever begin
      @(posedge clk); #1;
      axil.s_axil_bready = rnd_rdy ? 1'($urandom % 2) : 1'b1;
      axil.s_axil_rready = hold_r ? 1'b0 : (rnd_rdy ? 1'($urandom % 2) : 1'b1);
    end
  end

  // Transaction-level model state
  bit          m_have_aw, m_have_w, m_wbusy, m_rbusy, m_last_wr;
  logic [15:0] m_awaddr, m_raddr, m_last_waddr, m_last_raddr;
  logic [63:0] m_wdata, m_last_wdata;
  logic [7:0]  m_wstrb;
  logic [1:0]  m_bresp;
  int          m_wen_cyc = -1, m_ren_cyc = -1, m_b_from = 0, m_r_from = 0;
  // Observation log for directed literal checks
  int          wen_events = 0, last_wacc_cyc = 0, bv_rise_cyc = 0;
  logic [15:0] seen_waddr, seen_raddr;
  logic [63:0] seen_wdata, seen_rdata;
  logic [1:0]  seen_bresp;
  logic        prev_bvalid = 1'b0;
  byte         order_q[$];

  always @(negedge clk) begin : mon
    bit idle, wstart, e_aw, e_w, e_ar, e_wen, e_ren, e_bv, e_rv, aw_hs, w_hs, ar_hs;
    if (rst) begin
      check("rst_awready", axil.s_axil_awready, 0);
      check("rst_wready",  axil.s_axil_wready, 0);
      check("rst_arready", axil.s_axil_arready, 0);
      check("rst_bvalid",  axil.s_axil_bvalid, 0);
      check("rst_rvalid",  axil.s_axil_rvalid, 0);
      check("rst_resps",   {axil.s_axil_bresp, axil.s_axil_rresp}, 0);
      check("rst_rdata",   axil.s_axil_rdata, 0);
      check("rst_strobes", {wen, ren}, 0);
      check("rst_addrs",   {waddr, raddr}, 0);
      check("rst_wdata",   wdata_o, 0);
      m_have_aw = 0; m_have_w = 0; m_wbusy = 0; m_rbusy = 0; m_last_wr = 0;
      m_last_waddr = '0; m_last_raddr = '0; m_last_wdata = '0;
      m_wen_cyc = -1; m_ren_cyc = -1;
      prev_bvalid = 1'b0;
    end else begin
      idle = !m_wbusy && !m_rbusy && !m_have_aw && !m_have_w;
      e_aw = 0; e_w = 0; e_ar = 0;
      if (idle) begin
        wstart = (axil.s_axil_awvalid || axil.s_axil_wvalid) && (!axil.s_axil_arvalid || !m_last_wr);
        if (wstart) begin
          e_aw = axil.s_axil_awvalid;
          e_w  = axil.s_axil_wvalid;
        end else e_ar = axil.s_axil_arvalid;
      end else if (m_have_aw != m_have_w) begin
        e_aw = axil.s_axil_awvalid && !m_have_aw;
        e_w  = axil.s_axil_wvalid && !m_have_w;
      end
      check("awready", axil.s_axil_awready, e_aw);
      check("wready",  axil.s_axil_wready, e_w);
      check("arready", axil.s_axil_arready, e_ar);

      e_wen = (cyc == m_wen_cyc);
      if (e_wen) begin m_last_waddr = m_awaddr; m_last_wdata = m_wdata; end
      check("reg_wen", wen, e_wen);
      check("reg_waddr", waddr, m_last_waddr);
      check("reg_wdata", wdata_o, m_last_wdata);
      e_ren = (cyc == m_ren_cyc);
      if (e_ren) m_last_raddr = m_raddr;
      check("reg_ren", ren, e_ren);
      check("reg_raddr", raddr, m_last_raddr);

      e_bv = m_wbusy && (cyc >= m_b_from);
      check("bvalid", axil.s_axil_bvalid, e_bv);
      if (e_bv) check("bresp", axil.s_axil_bresp, m_bresp);
      e_rv = m_rbusy && (cyc >= m_r_from);
      check("rvalid", axil.s_axil_rvalid, e_rv);
      if (e_rv) begin
        check("rdata", axil.s_axil_rdata, reg_val(m_raddr));
        check("rresp", axil.s_axil_rresp, 2'b00);
      end

      if (wen) begin wen_events++; seen_waddr = waddr; seen_wdata = wdata_o; end
      if (ren) seen_raddr = raddr;
      if (axil.s_axil_bvalid && !prev_bvalid) bv_rise_cyc = cyc;
      prev_bvalid = axil.s_axil_bvalid;
      if (axil.s_axil_bvalid && axil.s_axil_bready) seen_bresp = axil.s_axil_bresp;
      if (axil.s_axil_rvalid && axil.s_axil_rready) seen_rdata = axil.s_axil_rdata;

      aw_hs = axil.s_axil_awvalid && e_aw;
      w_hs  = axil.s_axil_wvalid && e_w;
      ar_hs = axil.s_axil_arvalid && e_ar;
      if (aw_hs) begin m_have_aw = 1; m_awaddr = axil.s_axil_awaddr[18:3]; end
      if (w_hs) begin m_have_w = 1; m_wdata = axil.s_axil_wdata; m_wstrb = axil.s_axil_wstrb; end
      if ((aw_hs || w_hs) && m_have_aw && m_have_w) begin
        m_have_aw = 0; m_have_w = 0; m_wbusy = 1; m_last_wr = 1;
        m_wen_cyc = (m_wstrb == 8'hFF) ? cyc + 1 : -1;
        m_bresp   = (m_wstrb == 8'hFF) ? 2'b00 : 2'b10;
        m_b_from  = cyc + 2;
        last_wacc_cyc = cyc;
        order_q.push_back("W");
      end
      if (ar_hs) begin
        m_rbusy = 1; m_last_wr = 0;
        m_raddr = axil.s_axil_araddr[18:3];
        m_ren_cyc = cyc + 1;
        m_r_from  = cyc + 2 + L;
        order_q.push_back("R");
      end
      if (e_bv && axil.s_axil_bready) m_wbusy = 0;
      if (e_rv && axil.s_axil_rready) m_rbusy = 0;
    end
  end

  // Drivers: tasks start and end at posedge+1.
  task automatic drive_aw(input logic [31:0] a, input int dly);
    bit hs = 0;
    repeat (dly) begin @(posedge clk); #1; end
    axil.s_axil_awaddr = a; axil.s_axil_awvalid = 1'b1;
    for (int n = 0; n < 200 && !hs; n++) begin
      @(negedge clk);
      hs = axil.s_axil_awready;
    end
    @(posedge clk); #1;
    axil.s_axil_awvalid = 1'b0;
    if (!hs) timeout("aw");
  endtask

  task automatic drive_w(input logic [63:0] d, input logic [7:0] s, input int dly);
    bit hs = 0;
    repeat (dly) begin @(posedge clk); #1; end
    axil.s_axil_wdata = d; axil.s_axil_wstrb = s; axil.s_axil_wvalid = 1'b1;
    for (int n = 0; n < 200 && !hs; n++) begin
      @(negedge clk);
      hs = axil.s_axil_wready;
    end
    @(posedge clk); #1;
    axil.s_axil_wvalid = 1'b0;
    if (!hs) timeout("w");
  endtask

  task automatic drive_ar(input logic [31:0] a);
    bit hs = 0;
    axil.s_axil_araddr = a; axil.s_axil_arvalid = 1'b1;
    for (int n = 0; n < 200 && !hs; n++) begin
      @(negedge clk);
      hs = axil.s_axil_arready;
    end
    @(posedge clk); #1;
    axil.s_axil_arvalid = 1'b0;
    if (!hs) timeout("ar");
  endtask

  task automatic wait_b();
    bit hs = 0;
    for (int n = 0; n < 200 && !hs; n++) begin
      @(negedge clk);
      hs = axil.s_axil_bvalid && axil.s_axil_bready;
    end
    @(posedge clk); #1;
    if (!hs) timeout("b");
  endtask

  task automatic wait_r();
    bit hs = 0;
    for (int n = 0; n < 200 && !hs; n++) begin
      @(negedge clk);
      hs = axil.s_axil_rvalid && axil.s_axil_rready;
    end
    @(posedge clk); #1;
    if (!hs) timeout("r");
  endtask

  task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                          input int awd, input int wd);
    fork
      drive_aw(a, awd);
      drive_w(d, s, wd);
    join
    wait_b();
  endtask

  task automatic do_read(input logic [31:0] a);
    drive_ar(a);
    wait_r();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int    e0;
    bit    seen;
    string exp_order;
    axil.s_axil_awvalid = 0; axil.s_axil_wvalid = 0; axil.s_axil_arvalid = 0;
    axil.s_axil_awaddr = '0; axil.s_axil_araddr = '0;
    axil.s_axil_wdata = '0; axil.s_axil_wstrb = '0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Single write, AW and W together
    e0 = wen_events;
    do_write(32'h0000_0010, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 0);
    check("t1_wen_count", wen_events - e0, 1);
    check("t1_waddr", seen_waddr, 16'h0002);
    check("t1_wdata", seen_wdata, 64'h0123_4567_89AB_CDEF);
    check("t1_bresp", seen_bresp, 2'b00);
    check("t1_bvalid_delay", bv_rise_cyc - last_wacc_cyc, 2);

    // W four cycles ahead of AW, with a read pending during collection
    e0 = wen_events;
    order_q.delete();
    fork
      do_write(32'h0000_0018, 64'h1111_2222_3333_4444, 8'hFF, 4, 0);
      begin repeat (2) begin @(posedge clk); #1; end do_read(32'h0000_0040); end
    join
    check("t2_wen_count", wen_events - e0, 1);
    check("t2_waddr", seen_waddr, 16'h0003);
    check("t2_order_len", order_q.size(), 2);
    if (order_q.size() == 2) check("t2_order", {order_q[0], order_q[1]}, {8'h57, 8'h52});

    // Partial strobes
    e0 = wen_events;
    do_write(32'h0000_0020, 64'hFFFF_0000_FFFF_0000, 8'h0F, 0, 0);
    check("t3_wen_count", wen_events - e0, 0);
    check("t3_bresp", seen_bresp, 2'b10);

    // Read with rready held low
    hold_r = 1'b1;
    @(posedge clk); #1;
    drive_ar(32'h0000_0028);
    seen = 0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      seen = axil.s_axil_rvalid;
    end
    if (!seen) timeout("t4_rvalid");
    check("t4_raddr", seen_raddr, 16'h0005);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t4_rvalid_hold", axil.s_axil_rvalid, 1'b1);
      check("t4_rdata_hold", axil.s_axil_rdata, 64'hDEAD_BEEF_0000_0005);
    end
    @(posedge clk); #1;
    hold_r = 1'b0;
    wait_r();
    check("t4_rdata", seen_rdata, 64'hDEAD_BEEF_0000_0005);

    // All three valids pending: service alternates
    order_q.delete();
    fork
      begin
        do_write(32'h0000_0100, 64'hA5A5_A5A5_0000_0001, 8'hFF, 0, 0);
        do_write(32'h0000_0108, 64'hA5A5_A5A5_0000_0002, 8'hFF, 0, 0);
      end
      begin
        do_read(32'h0000_0200);
        do_read(32'h0000_0208);
      end
    join
    exp_order = "WRWR";
    check("t5_order_len", order_q.size(), 4);
    for (int i = 0; i < 4 && i < order_q.size(); i++) check("t5_order", order_q[i], exp_order[i]);

    // Reset while waiting on read data
    drive_ar(32'h0000_0030);
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    e0 = wen_events;
    repeat (10) begin @(posedge clk); #1; end
    check("t6_no_wen", wen_events - e0, 0);
    do_read(32'h0000_0038);
    check("t6_raddr", seen_raddr, 16'h0007);
    check("t6_rdata", seen_rdata, 64'hDEAD_BEEF_0000_0007);

    // Randomized traffic
    rnd_rdy = 1'b1;
    for (int t = 0; t < 40; t++) begin
      int unsigned kind;
      logic [31:0] wa, ra;
      logic [63:0] wd;
      logic [7:0]  ws;
      kind = $urandom_range(0, 2);
      wa = $urandom;
      ra = $urandom;
      wd = {$urandom, $urandom};
      ws = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
      case (kind)
        0: do_write(wa, wd, ws, $urandom_range(0, 3), $urandom_range(0, 3));
        1: do_read(ra);
        default: fork
          do_write(wa, wd, ws, $urandom_range(0, 3), $urandom_range(0, 3));
          do_read(ra);
        join
      endcase
    end
    repeat (5) begin @(posedge clk); #1; end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end
endmodule
